// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO register bus.
// Used by the bus master and the register block.
package mmio_pkg;

   // Command opcode: write or read
   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_t;

   // Bus master FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_RWAIT = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // Address bit that selects the MMIO register window
   localparam int unsigned MMIO_SEL_BIT = 15;

   // Register offsets inside the window
   localparam logic [3:0] OFF_CONFIG = 4'h0;
   localparam logic [3:0] OFF_INPUT  = 4'h4;
   localparam logic [3:0] OFF_OUTPUT = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   // Saturating 8-bit increment, used by the error counter
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = 8'hFF;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mmio_addr_check.sv
// Combinational address legality check for MMIO commands.
// A read must hit the MMIO window and be word-aligned. A write
// additionally must target one of the writable offsets.
module mmio_addr_check
   import mmio_pkg::*;
(
   input  op_t         i_op,
   input  logic [31:0] i_addr,
   output logic        o_mapped,
   output logic        o_is_write_legal
);

   logic w_sel;
   logic w_aligned;
   logic w_wr_off;
   logic w_unused;

   // Address bits outside the select bit and the low nibble are don't-care
   assign w_unused = ^{i_addr[31:16], i_addr[14:4]};

   // Decode window select, alignment and writable offsets
   always_comb begin
      w_sel            = i_addr[MMIO_SEL_BIT];
      w_aligned        = (i_addr[1:0] == 2'b00);
      w_wr_off         = (i_addr[3:0] == OFF_CONFIG) || (i_addr[3:0] == OFF_INPUT);
      o_is_write_legal = w_sel && w_aligned && w_wr_off;
      if (i_op == OP_RD) begin
         o_mapped = w_sel && w_aligned;
      end else begin
         o_mapped = o_is_write_legal;
      end
   end

endmodule

// File: rtl/mmio_master.sv
// Single-beat MMIO bus master.
// It turns a valid/ready command stream into register-bus strobes
// and returns exactly one response per accepted command.
module mmio_master
   import mmio_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned CNT_W        = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid_in,
   output logic             cmd_ready_out,
   input  logic             cmd_op_in,
   input  logic [31:0]      cmd_addr_in,
   input  logic [31:0]      cmd_data_in,
   output logic             rsp_valid_out,
   input  logic             rsp_ready_in,
   output logic [31:0]      rsp_data_out,
   output logic             rsp_err_out,
   output logic [31:0]      addr_out,
   output logic [31:0]      wdata_out,
   output logic             wr_out,
   output logic             rd_out,
   input  logic [31:0]      rdata_in,
   output logic             busy_out,
   output logic [CNT_W-1:0] wr_count_out,
   output logic [CNT_W-1:0] rd_count_out,
   output logic [7:0]       err_count_out
);

   localparam logic [2:0]       LAT_INIT = 3'(READ_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next_state;
   op_t              w_op;
   logic             w_mapped;
   logic             w_wr_legal;
   logic             w_accept;
   logic             w_capture;
   logic [2:0]       r_lat_cnt;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_err;
   logic [CNT_W-1:0] r_wr_cnt;
   logic [CNT_W-1:0] r_rd_cnt;
   logic [7:0]       r_err_cnt;

   assign w_op      = op_t'(cmd_op_in);
   assign w_accept  = cmd_valid_in && (r_state == ST_IDLE);
   assign w_capture = (r_state == ST_RWAIT) && (r_lat_cnt == 3'd1);

   mmio_addr_check u_addr_check (
      .i_op             (w_op),
      .i_addr           (cmd_addr_in),
      .o_mapped         (w_mapped),
      .o_is_write_legal (w_wr_legal)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid_in) begin
               if (!w_mapped) begin
                  w_next_state = ST_RESP;
               end else if (w_op == OP_RD) begin
                  w_next_state = ST_READ;
               end else if (w_wr_legal) begin
                  w_next_state = ST_WRITE;
               end else begin
                  w_next_state = ST_RESP;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WRITE: w_next_state = ST_RESP;
         ST_READ:  w_next_state = ST_RWAIT;
         ST_RWAIT: begin
            if (r_lat_cnt == 3'd1) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_RWAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready_in) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // FSM output decode from the registered state only
   always_comb begin
      cmd_ready_out = 1'b0;
      busy_out      = 1'b1;
      wr_out        = 1'b0;
      rd_out        = 1'b0;
      rsp_valid_out = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready_out = 1'b1;
            busy_out      = 1'b0;
         end
         ST_WRITE: wr_out        = 1'b1;
         ST_READ:  rd_out        = 1'b1;
         ST_RWAIT: busy_out      = 1'b1;
         ST_RESP:  rsp_valid_out = 1'b1;
         default:  busy_out      = 1'b1;
      endcase
   end

   // Latch the command on accept and capture read data at the end of the wait
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_rsp_data <= 32'd0;
         r_rsp_err  <= 1'b0;
      end else if (w_accept) begin
         r_addr     <= cmd_addr_in;
         r_wdata    <= cmd_data_in;
         r_rsp_data <= 32'd0;
         r_rsp_err  <= !w_mapped;
      end else if (w_capture) begin
         r_rsp_data <= rdata_in;
      end
   end

   // Read latency countdown: loaded in READ, stepped down in RWAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lat_cnt <= 3'd0;
      end else if (r_state == ST_READ) begin
         r_lat_cnt <= LAT_INIT;
      end else if (r_state == ST_RWAIT) begin
         r_lat_cnt <= r_lat_cnt - 3'd1;
      end
   end

   // Completed-access counters (wrapping) and rejected-command counter (saturating)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt  <= {CNT_W{1'b0}};
         r_rd_cnt  <= {CNT_W{1'b0}};
         r_err_cnt <= 8'd0;
      end else begin
         if (r_state == ST_WRITE) begin
            r_wr_cnt <= r_wr_cnt + CNT_ONE;
         end
         if (w_capture) begin
            r_rd_cnt <= r_rd_cnt + CNT_ONE;
         end
         if (w_accept && !w_mapped) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
         end
      end
   end

   assign addr_out      = r_addr;
   assign wdata_out     = r_wdata;
   assign rsp_data_out  = r_rsp_data;
   assign rsp_err_out   = r_rsp_err;
   assign wr_count_out  = r_wr_cnt;
   assign rd_count_out  = r_rd_cnt;
   assign err_count_out = r_err_cnt;

endmodule

// File: tb/tb_mmio_master.sv
// Scoreboard bench for mmio_master with a small behavioural register block.
// Register model: CONFIG (0x0) and INPUT (0x4) are writable,
// OUTPUT (0x8) reads INPUT*9+2, and STATUS (0xC) reads CONFIG.
module tb_mmio_master;
   import mmio_pkg::*;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_in;
   logic        cmd_ready_out;
   logic        cmd_op_in;
   logic [31:0] cmd_addr_in;
   logic [31:0] cmd_data_in;
   logic        rsp_valid_out;
   logic        rsp_ready_in;
   logic [31:0] rsp_data_out;
   logic        rsp_err_out;
   logic [31:0] addr_out;
   logic [31:0] wdata_out;
   logic        wr_out;
   logic        rd_out;
   logic [31:0] rdata_in;
   logic        busy_out;
   logic [15:0] wr_count_out;
   logic [15:0] rd_count_out;
   logic [7:0]  err_count_out;

   logic [31:0] reg_cfg;
   logic [31:0] reg_inp;

   rsp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   wr_pulses    = 0;
   int   rd_pulses    = 0;
   int   both_high    = 0;

   always #5 clk = ~clk;

   mmio_master #(.READ_LATENCY(1), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid_in  (cmd_valid_in),
      .cmd_ready_out (cmd_ready_out),
      .cmd_op_in     (cmd_op_in),
      .cmd_addr_in   (cmd_addr_in),
      .cmd_data_in   (cmd_data_in),
      .rsp_valid_out (rsp_valid_out),
      .rsp_ready_in  (rsp_ready_in),
      .rsp_data_out  (rsp_data_out),
      .rsp_err_out   (rsp_err_out),
      .addr_out      (addr_out),
      .wdata_out     (wdata_out),
      .wr_out        (wr_out),
      .rd_out        (rd_out),
      .rdata_in      (rdata_in),
      .busy_out      (busy_out),
      .wr_count_out  (wr_count_out),
      .rd_count_out  (rd_count_out),
      .err_count_out (err_count_out)
   );

   // Behavioural register block: synchronous reset, registered read data
   always @(posedge clk) begin
      if (rst) begin
         reg_cfg  <= 32'd0;
         reg_inp  <= 32'd0;
         rdata_in <= 32'd0;
      end else begin
         if (wr_out) begin
            if (addr_out[3:0] == 4'h0) reg_cfg <= wdata_out;
            if (addr_out[3:0] == 4'h4) reg_inp <= wdata_out;
         end
         if (rd_out) begin
            case (addr_out[3:0])
               4'h0:    rdata_in <= reg_cfg;
               4'h4:    rdata_in <= reg_inp;
               4'h8:    rdata_in <= reg_inp * 32'd9 + 32'd2;
               4'hC:    rdata_in <= reg_cfg;
               default: rdata_in <= 32'd0;
            endcase
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: strobe bookkeeping and scoreboard pop on each response handshake
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (wr_out) wr_pulses++;
            if (rd_out) rd_pulses++;
            if (wr_out && rd_out) both_high++;
            if (rsp_valid_out && rsp_ready_in) begin
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL unexpected_rsp: got data 0x%08h err %0b with nothing expected",
                           rsp_data_out, rsp_err_out);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_data", rsp_data_out, e.data);
                  check("rsp_err", {31'd0, rsp_err_out}, {31'd0, e.err});
               end
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_cmd_ready"}, {31'd0, cmd_ready_out}, 32'd1);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid_out}, 32'd0);
      check({tag, "_rsp_data"},  rsp_data_out, 32'd0);
      check({tag, "_rsp_err"},   {31'd0, rsp_err_out}, 32'd0);
      check({tag, "_addr"},      addr_out, 32'd0);
      check({tag, "_wdata"},     wdata_out, 32'd0);
      check({tag, "_strobes"},   {30'd0, wr_out, rd_out}, 32'd0);
      check({tag, "_busy"},      {31'd0, busy_out}, 32'd0);
      check({tag, "_counts"},    {wr_count_out, rd_count_out}, 32'd0);
      check({tag, "_err_count"}, {24'd0, err_count_out}, 32'd0);
   endtask

   // Issue one command, push its expected response, and check accept-to-valid latency
   task automatic send(input logic op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                       input string name);
      rsp_t r;
      int   n;
      r.err  = exp_e;
      r.data = exp_d;
      exp_q.push_back(r);
      cmd_op_in    = op;
      cmd_addr_in  = a;
      cmd_data_in  = d;
      cmd_valid_in = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready_out && n < 100);
      if (!cmd_ready_out) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s_accept: cmd_ready_out stayed 0 for %0d cycles, required 1", name, n);
      end
      @(posedge clk);
      #1;
      cmd_valid_in = 1'b0;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         n++;
         if (rsp_valid_out) break;
      end
      check({name, "_lat"}, n, exp_lat);
   endtask

   // Wait until the monitor has consumed every expected response
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p_wr;
      int p_rd;
      rsp_t r;

      rst          = 1'b1;
      cmd_valid_in = 1'b0;
      cmd_op_in    = 1'b0;
      cmd_addr_in  = 32'd0;
      cmd_data_in  = 32'd0;
      rsp_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_ready", {31'd0, cmd_ready_out}, 32'd1);

      // Write INPUT=5, read OUTPUT -> 5*9+2 = 47
      p_wr = wr_pulses;
      p_rd = rd_pulses;
      send(OP_WR, 32'h0000_8004, 32'd5, 32'd0, 1'b0, 2, "wr_input");
      drain();
      check("wr_pulse_len", wr_pulses - p_wr, 32'd1);
      send(OP_RD, 32'h0000_8008, 32'd0, 32'd47, 1'b0, 3, "rd_output");
      drain();
      check("rd_pulse_len", rd_pulses - p_rd, 32'd1);
      check("wr_count_1", {16'd0, wr_count_out}, 32'd1);
      check("rd_count_1", {16'd0, rd_count_out}, 32'd1);

      // CONFIG=0xA5, visible through STATUS and CONFIG
      send(OP_WR, 32'h0000_8000, 32'h0000_00A5, 32'd0, 1'b0, 2, "wr_config");
      send(OP_RD, 32'h0000_800C, 32'd0, 32'h0000_00A5, 1'b0, 3, "rd_status");
      send(OP_RD, 32'h0000_8000, 32'd0, 32'h0000_00A5, 1'b0, 3, "rd_config");
      drain();

      // Unmapped read: select bit clear
      p_rd = rd_pulses;
      send(OP_RD, 32'h0000_0004, 32'd0, 32'd0, 1'b1, 1, "rd_unmapped");
      drain();
      check("unmapped_no_rd", rd_pulses - p_rd, 32'd0);
      check("err_count_1", {24'd0, err_count_out}, 32'd1);

      // Write to a read-only offset is rejected, bus regs still hold it
      p_wr = wr_pulses;
      send(OP_WR, 32'h0000_8008, 32'd7, 32'd0, 1'b1, 1, "wr_readonly");
      drain();
      check("readonly_no_wr", wr_pulses - p_wr, 32'd0);
      check("err_count_2", {24'd0, err_count_out}, 32'd2);
      check("unmapped_addr_held", addr_out, 32'h0000_8008);
      check("unmapped_wdata_held", wdata_out, 32'd7);
      send(OP_RD, 32'h0000_8004, 32'd0, 32'd5, 1'b0, 3, "rd_input_kept");
      drain();

      // Misaligned read rejected; high address bits are don't-care
      send(OP_RD, 32'h0000_8006, 32'd0, 32'd0, 1'b1, 1, "rd_misaligned");
      send(OP_RD, 32'hFFFF_8004, 32'd0, 32'd5, 1'b0, 3, "rd_high_bits");
      drain();
      check("err_count_3", {24'd0, err_count_out}, 32'd3);

      // Backpressure: hold the response for 10 cycles with a command waiting
      rsp_ready_in = 1'b0;
      send(OP_RD, 32'h0000_8004, 32'd0, 32'd5, 1'b0, 3, "stall_rd");
      @(posedge clk);
      #1;
      r.err  = 1'b0;
      r.data = 32'h0000_00A5;
      exp_q.push_back(r);
      cmd_op_in    = OP_RD;
      cmd_addr_in  = 32'h0000_8000;
      cmd_data_in  = 32'd0;
      cmd_valid_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_payload", {rsp_valid_out, rsp_err_out, cmd_ready_out, 29'd0, rsp_data_out[0]},
               {1'b1, 1'b0, 1'b0, 29'd0, 1'b1});
         check("stall_data", rsp_data_out, 32'd5);
      end
      @(posedge clk);
      #1;
      rsp_ready_in = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("stall_idle_after_hs", {30'd0, cmd_ready_out, rd_out}, 32'd2);
      @(negedge clk);
      check("stall_accept_next", {31'd0, rd_out}, 32'd1);
      cmd_valid_in = 1'b0;
      drain();
      check("wr_count_2", {16'd0, wr_count_out}, 32'd2);
      check("rd_count_7", {16'd0, rd_count_out}, 32'd7);

      // Reset while waiting for read data
      cmd_op_in    = OP_RD;
      cmd_addr_in  = 32'h0000_8004;
      cmd_valid_in = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid_in = 1'b0;
      @(posedge clk);
      #1;
      check("in_rwait", {30'd0, busy_out, rd_out}, 32'd2);
      rst = 1'b1;
      #1;
      check_reset_state("mid_reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("no_rsp_after_reset", {31'd0, rsp_valid_out}, 32'd0);
      end
      @(posedge clk);
      #1;
      send(OP_RD, 32'h0000_8004, 32'd0, 32'd0, 1'b0, 3, "post_reset_rd");
      drain();
      check("post_reset_rd_count", {16'd0, rd_count_out}, 32'd1);

      check("strobes_exclusive", both_high, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
